// File: rtl/vga_pkg.sv
// Shared geometry, park codes and scheduler state encodings for the VGA debug overlay.
package vga_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;
  localparam int X_W     = 11;
  localparam int Y_W     = 10;

  // Park coordinates lie outside any visible beam position, so the renderer stays dark.
  localparam logic [X_W-1:0] X_PARK = 11'h7FF;
  localparam logic [Y_W-1:0] Y_PARK = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/hex_field_sched_nibble_sel.sv
// Picks one hex digit (MSB first) of one snapshotted field for the glyph renderer.
module hex_nibble_sel #(
  parameter int N_FIELDS = 4,
  parameter int DIGITS   = 8,
  localparam int FW      = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1,
  localparam int DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic [N_FIELDS*DIGITS*4-1:0] snap,
  input  logic [FW-1:0]                field_idx,
  input  logic [DW-1:0]                digit_idx,
  output logic [3:0]                   nibble
);

  // Fully decoded mux keeps every slice constant and never indexes past the word.
  always_comb begin
    nibble = 4'h0;
    for (int f = 0; f < N_FIELDS; f++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (field_idx == FW'(f) && digit_idx == DW'(d)) begin
          nibble = snap[(f*DIGITS + (DIGITS-1-d))*4 +: 4];
        end
      end
    end
  end

endmodule

// File: rtl/hex_field_sched.sv
// Sequences one 8x8 hex glyph renderer across N_FIELDS rows of frame-snapshotted CPU words.
module hex_field_sched
  import vga_pkg::*;
#(
  parameter int             N_FIELDS  = 4,
  parameter int             DIGITS    = 8,
  parameter logic [10:0]    X0        = 11'd64,
  parameter logic [9:0]     Y0        = 10'd32,
  parameter logic [9:0]     ROW_PITCH = 10'd12,
  parameter logic [10:0]    DIG_PITCH = 11'd8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [X_W-1:0]               x_count,
  input  logic [Y_W-1:0]               y_count,
  input  logic [N_FIELDS*DIGITS*4-1:0] field_data,
  input  logic [N_FIELDS-1:0]          field_en,
  output logic [X_W-1:0]               x_pos,
  output logic [Y_W-1:0]               y_pos,
  output logic [3:0]                   num_add,
  output logic                         busy,
  output logic                         frame_tick
);

  localparam int FW = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  sched_state_t                state;
  logic [N_FIELDS*DIGITS*4-1:0] snap;
  logic [FW-1:0]               field_idx;
  logic [DW-1:0]               digit_idx;

  logic                        line_start;
  logic                        frame_start;
  logic                        last_digit;
  logic [N_FIELDS-1:0]         band_hit;
  logic [Y_W-1:0]              band_top [N_FIELDS];
  logic                        hit;
  logic [FW-1:0]               hit_f;
  logic [FW-1:0]               sel_field;
  logic [DW-1:0]               sel_digit;
  logic [3:0]                  nibble;

  assign line_start  = (x_count == '0);
  assign frame_start = line_start && (y_count == '0);
  assign last_digit  = (digit_idx == DW'(DIGITS-1));

  // One comparator per row band; the glyph is GLYPH_H lines tall from the row top.
  for (genvar g = 0; g < N_FIELDS; g++) begin : g_band
    localparam int TOP = int'(Y0) + g * int'(ROW_PITCH);
    assign band_top[g] = Y_W'(TOP);
    assign band_hit[g] = field_en[g] && (int'(y_count) >= TOP) &&
                         (int'(y_count) < TOP + GLYPH_H);
  end

  // Downward scan so the lowest enabled field is the one left standing.
  always_comb begin
    hit   = 1'b0;
    hit_f = '0;
    for (int i = N_FIELDS-1; i >= 0; i--) begin
      if (band_hit[i]) begin
        hit   = 1'b1;
        hit_f = FW'(i);
      end
    end
  end

  // Line start loads digit 0 of the new row; otherwise look one digit ahead.
  assign sel_field = line_start ? hit_f : field_idx;
  assign sel_digit = line_start ? '0 : digit_idx + DW'(1);

  hex_nibble_sel #(
    .N_FIELDS (N_FIELDS),
    .DIGITS   (DIGITS)
  ) u_nibble_sel (
    .snap      (snap),
    .field_idx (sel_field),
    .digit_idx (sel_digit),
    .nibble    (nibble)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      field_idx  <= '0;
      digit_idx  <= '0;
      x_pos      <= X_PARK;
      y_pos      <= Y_PARK;
      num_add    <= 4'h0;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) begin
        snap <= field_data;
      end
      if (line_start) begin
        if (hit) begin
          state     <= ROW;
          busy      <= 1'b1;
          field_idx <= hit_f;
          digit_idx <= '0;
          x_pos     <= X0;
          y_pos     <= band_top[hit_f];
          num_add   <= nibble;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
          x_pos <= X_PARK;
          y_pos <= Y_PARK;
        end
      end else if (state == ROW && x_count == x_pos) begin
        // The renderer latches num_add on this edge, so advance to the next digit now.
        if (!last_digit) begin
          digit_idx <= digit_idx + DW'(1);
          x_pos     <= x_pos + DIG_PITCH;
          num_add   <= nibble;
        end else begin
          state <= DONE;
          busy  <= 1'b0;
          x_pos <= X_PARK;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_field_sched.sv
// Directed bench for hex_field_sched: drives beam coordinates line by line and checks glyph sequencing.
module tb_hex_field_sched;

  localparam int H = 140;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [10:0]  x_count;
  logic [9:0]   y_count;
  logic [127:0] field_data;
  logic [3:0]   field_en;
  logic [10:0]  x_pos;
  logic [9:0]   y_pos;
  logic [3:0]   num_add;
  logic         busy;
  logic         frame_tick;

  int           total = 0;
  int           fails = 0;
  int           nseen;
  logic [31:0]  seen_word;

  always #5 clk = ~clk;

  hex_field_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_count    (x_count),
    .y_count    (y_count),
    .field_data (field_data),
    .field_en   (field_en),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .num_add    (num_add),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one beam position; record the digit the renderer latches on the coming edge.
  task automatic step(input int x, input int y);
    @(negedge clk);
    x_count = 11'(x);
    y_count = 10'(y);
    if (busy === 1'b1 && x_pos === 11'(x)) begin
      seen_word = {seen_word[27:0], num_add};
      nseen++;
    end
  endtask

  // ev_kind 1: drop all field_en at ev_x; ev_kind 2: pulse rst_n low at ev_x.
  task automatic run_line(input int y, input int ev_x, input int ev_kind);
    nseen     = 0;
    seen_word = 32'h0;
    for (int x = 0; x < H; x++) begin
      step(x, y);
      if (x == ev_x && ev_kind == 1) field_en = 4'b0000;
      if (x == ev_x && ev_kind == 2) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_xpos", 32'(x_pos), 32'h7FF);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_num", 32'(num_add), 32'h0);
      end
      if (x == ev_x + 1 && ev_kind == 2) rst_n = 1'b1;
    end
  endtask

  task automatic frame();
    step(0, 0);
    step(1, 0);
    check("frame_tick_hi", 32'(frame_tick), 32'h1);
    step(2, 0);
    check("frame_tick_lo", 32'(frame_tick), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    field_en   = 4'b0000;
    field_data = '0;
    x_count    = '0;
    y_count    = '0;

    // Reset with a random beam
    repeat (4) begin
      @(negedge clk);
      x_count = 11'($urandom);
      y_count = 10'($urandom);
    end
    check("rst_xpos", 32'(x_pos), 32'h7FF);
    check("rst_ypos", 32'(y_pos), 32'h3FF);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_num", 32'(num_add), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    x_count = 11'd5;
    y_count = 10'd5;
    rst_n   = 1'b1;

    // Single row, MSB-first digits
    field_data = {96'h0, 32'h1234ABCD};
    field_en   = 4'b0001;
    frame();
    run_line(32, -1, 0);
    check("row0_count", 32'(nseen), 32'd8);
    check("row0_word", seen_word, 32'h1234ABCD);
    check("row0_end_xpos", 32'(x_pos), 32'h7FF);
    check("row0_end_busy", 32'(busy), 32'h0);
    check("row0_end_ypos", 32'(y_pos), 32'd32);

    // Tear-free: data changes mid-frame, display holds the snapshot
    for (int y = 33; y <= 39; y++) begin
      if (y == 35) field_data[31:0] = 32'hDEADBEEF;
      run_line(y, -1, 0);
      check("tear_word", seen_word, 32'h1234ABCD);
    end
    frame();
    run_line(32, -1, 0);
    check("new_word", seen_word, 32'hDEADBEEF);

    // Alternate rows enabled
    field_data = {32'h76543210, 32'h0F0F0F0F, 32'h89ABCDEF, 32'h1234ABCD};
    field_en   = 4'b1010;
    frame();
    run_line(32, -1, 0);
    check("en_f0_off_count", 32'(nseen), 32'd0);
    check("en_f0_off_ypos", 32'(y_pos), 32'h3FF);
    check("en_f0_off_busy", 32'(busy), 32'h0);
    run_line(44, -1, 0);
    check("en_f1_word", seen_word, 32'h89ABCDEF);
    check("en_f1_ypos", 32'(y_pos), 32'd44);
    run_line(51, -1, 0);
    check("en_f1_last_word", seen_word, 32'h89ABCDEF);
    run_line(52, -1, 0);
    check("en_gap_count", 32'(nseen), 32'd0);
    check("en_gap_ypos", 32'(y_pos), 32'h3FF);
    run_line(56, -1, 0);
    check("en_f2_off_count", 32'(nseen), 32'd0);
    run_line(68, -1, 0);
    check("en_f3_word", seen_word, 32'h76543210);
    check("en_f3_ypos", 32'(y_pos), 32'd68);

    // Band edges and field_en dropped mid-row
    field_en = 4'b0001;
    run_line(39, -1, 0);
    check("last_line_word", seen_word, 32'h1234ABCD);
    check("last_line_ypos", 32'(y_pos), 32'd32);
    run_line(40, -1, 0);
    check("below_count", 32'(nseen), 32'd0);
    check("below_ypos", 32'(y_pos), 32'h3FF);
    run_line(43, -1, 0);
    check("gap43_count", 32'(nseen), 32'd0);
    run_line(36, 80, 1);
    check("en_drop_count", 32'(nseen), 32'd8);
    check("en_drop_word", seen_word, 32'h1234ABCD);
    run_line(37, -1, 0);
    check("en_drop_next", 32'(nseen), 32'd0);

    // Reset mid-row: park at once, snapshot cleared
    field_en = 4'b0001;
    run_line(36, 90, 2);
    check("rst_row_count", 32'(nseen), 32'd4);
    check("rst_row_word", seen_word, 32'h00001234);
    run_line(37, -1, 0);
    check("post_rst_count", 32'(nseen), 32'd8);
    check("post_rst_word", seen_word, 32'h0);
    check("post_rst_ypos", 32'(y_pos), 32'd32);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
